pipeline_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB).
- Combines the ID-stage load-use stall, ID branch-misprediction redirect, multi-cycle EX busy and multi-cycle MEM busy into per-stage stall/bubble/flush controls, using a fixed priority.
- Owns the PC redirect pulse.
- Tracks an in-flight instruction fetch that must be discarded after a redirect.
- Keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: fixed-priority hazard
// resolution, PC redirect strobe, stale-fetch drop tracking and perf counters.
module pipeline_hazard_ctrl #(
   parameter int PC_W  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_load_stall,
   input  logic             id_redirect,
   input  logic [PC_W-1:0]  id_redirect_pc,
   input  logic             ex_busy,
   input  logic             mem_busy,
   input  logic             if_req_busy,
   input  logic             if_resp_valid,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_bubble,
   output logic             ex_mem_stall,
   output logic             ex_mem_bubble,
   output logic             mem_wb_bubble,
   output logic             pc_redirect,
   output logic [PC_W-1:0]  pc_redirect_target,
   output logic             if_drop_resp,
   output logic             drop_pending,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [0:0] {RUN = 1'b0, DROP = 1'b1} state_t;

   state_t           state;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;
   logic             in_run;

   assign in_run = (state == RUN);

   // Priority chain: back-end busy wins over ID hazards; ID requests are
   // ignored while draining a stale fetch because ID then holds a bubble.
   always_comb begin
      pc_stall           = 1'b0;
      if_id_stall        = 1'b0;
      if_id_flush        = 1'b0;
      id_ex_stall        = 1'b0;
      id_ex_bubble       = 1'b0;
      ex_mem_stall       = 1'b0;
      ex_mem_bubble      = 1'b0;
      mem_wb_bubble      = 1'b0;
      pc_redirect        = 1'b0;
      pc_redirect_target = '0;
      if_drop_resp       = 1'b0;
      drop_pending       = 1'b0;
      stall_cnt          = '0;
      flush_cnt          = '0;
      if (!reset) begin
         if (mem_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
         end else if (ex_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
         end else if (in_run && id_load_stall) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_bubble  = 1'b1;
         end else if (in_run && id_redirect) begin
            pc_redirect        = 1'b1;
            pc_redirect_target = id_redirect_pc;
            if_id_flush        = 1'b1;
         end
         if_drop_resp = !in_run && if_resp_valid;
         drop_pending = !in_run;
         stall_cnt    = stall_q;
         flush_cnt    = flush_q;
      end
   end

   // A redirect accepted while the old-path fetch is still outstanding must
   // discard that response when it eventually arrives.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= RUN;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (pc_stall)
            stall_q <= stall_q + CNT_W'(1);
         if (pc_redirect)
            flush_q <= flush_q + CNT_W'(1);
         case (state)
            RUN:     if (pc_redirect && if_req_busy && !if_resp_valid) state <= DROP;
            DROP:    if (if_resp_valid) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with narrow counters so wrap-around
// is reachable in a short run.
module tb_pipeline_hazard_ctrl;

   localparam int PC_W  = 64;
   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             id_load_stall;
   logic             id_redirect;
   logic [PC_W-1:0]  id_redirect_pc;
   logic             ex_busy;
   logic             mem_busy;
   logic             if_req_busy;
   logic             if_resp_valid;
   logic             pc_stall;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_ex_stall;
   logic             id_ex_bubble;
   logic             ex_mem_stall;
   logic             ex_mem_bubble;
   logic             mem_wb_bubble;
   logic             pc_redirect;
   logic [PC_W-1:0]  pc_redirect_target;
   logic             if_drop_resp;
   logic             drop_pending;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int checks   = 0;
   int failures = 0;

   pipeline_hazard_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clock              (clock),
      .reset              (reset),
      .id_load_stall      (id_load_stall),
      .id_redirect        (id_redirect),
      .id_redirect_pc     (id_redirect_pc),
      .ex_busy            (ex_busy),
      .mem_busy           (mem_busy),
      .if_req_busy        (if_req_busy),
      .if_resp_valid      (if_resp_valid),
      .pc_stall           (pc_stall),
      .if_id_stall        (if_id_stall),
      .if_id_flush        (if_id_flush),
      .id_ex_stall        (id_ex_stall),
      .id_ex_bubble       (id_ex_bubble),
      .ex_mem_stall       (ex_mem_stall),
      .ex_mem_bubble      (ex_mem_bubble),
      .mem_wb_bubble      (mem_wb_bubble),
      .pc_redirect        (pc_redirect),
      .pc_redirect_target (pc_redirect_target),
      .if_drop_resp       (if_drop_resp),
      .drop_pending       (drop_pending),
      .stall_cnt          (stall_cnt),
      .flush_cnt          (flush_cnt)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs;
      id_load_stall  = 1'b0;
      id_redirect    = 1'b0;
      id_redirect_pc = '0;
      ex_busy        = 1'b0;
      mem_busy       = 1'b0;
      if_req_busy    = 1'b0;
      if_resp_valid  = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      clear_inputs();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      mem_busy = 1'b1; id_redirect = 1'b1; id_redirect_pc = 64'h1234; if_resp_valid = 1'b1;
      #1;
      checks++; if (pc_stall !== 1'b0) begin failures++; $display("FAIL rst_pc_stall got=%0b exp=0", pc_stall); end
      checks++; if (mem_wb_bubble !== 1'b0) begin failures++; $display("FAIL rst_mem_wb_bubble got=%0b exp=0", mem_wb_bubble); end
      checks++; if (pc_redirect !== 1'b0 || pc_redirect_target !== 64'h0) begin failures++; $display("FAIL rst_redirect got=%0b/%0h exp=0/0", pc_redirect, pc_redirect_target); end
      checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      checks++; if (drop_pending !== 1'b0 || if_drop_resp !== 1'b0) begin failures++; $display("FAIL rst_drop got=%0b/%0b exp=0/0", drop_pending, if_drop_resp); end
      clear_inputs();
      reset = 1'b0;
   endtask

   task automatic test_load_use;
      do_reset();
      id_load_stall = 1'b1;
      #1;
      checks++; if (pc_stall !== 1'b1 || if_id_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b%0b exp=11", pc_stall, if_id_stall); end
      checks++; if (id_ex_bubble !== 1'b1 || id_ex_stall !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0b/%0b exp=1/0", id_ex_bubble, id_ex_stall); end
      checks++; if (ex_mem_bubble !== 1'b0 || mem_wb_bubble !== 1'b0 || if_id_flush !== 1'b0) begin failures++; $display("FAIL lu_other got=%0b%0b%0b exp=000", ex_mem_bubble, mem_wb_bubble, if_id_flush); end
      tick();
      id_load_stall = 1'b0;
      #1;
      checks++; if (pc_stall !== 1'b0 || id_ex_bubble !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b/%0b exp=0/0", pc_stall, id_ex_bubble); end
      checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
   endtask

   task automatic test_priority;
      do_reset();
      mem_busy = 1'b1; ex_busy = 1'b1; id_redirect = 1'b1; id_redirect_pc = 64'h8000_0010;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (ex_mem_stall !== 1'b1 || mem_wb_bubble !== 1'b1 || ex_mem_bubble !== 1'b0) begin failures++; $display("FAIL pri_mem_c%0d got=%0b%0b%0b exp=110", i, ex_mem_stall, mem_wb_bubble, ex_mem_bubble); end
         checks++; if (pc_redirect !== 1'b0 || pc_redirect_target !== 64'h0 || if_id_flush !== 1'b0) begin failures++; $display("FAIL pri_mem_redir_c%0d got=%0b/%0h/%0b exp=0/0/0", i, pc_redirect, pc_redirect_target, if_id_flush); end
         tick();
      end
      mem_busy = 1'b0;
      #1;
      checks++; if (ex_mem_bubble !== 1'b1 || ex_mem_stall !== 1'b0 || id_ex_stall !== 1'b1 || mem_wb_bubble !== 1'b0) begin failures++; $display("FAIL pri_ex got=%0b%0b%0b%0b exp=1010", ex_mem_bubble, ex_mem_stall, id_ex_stall, mem_wb_bubble); end
      checks++; if (pc_redirect !== 1'b0) begin failures++; $display("FAIL pri_ex_redir got=%0b exp=0", pc_redirect); end
      tick();
      ex_busy = 1'b0;
      #1;
      checks++; if (pc_redirect !== 1'b1 || pc_redirect_target !== 64'h8000_0010) begin failures++; $display("FAIL pri_redir got=%0b/%0h exp=1/80000010", pc_redirect, pc_redirect_target); end
      checks++; if (if_id_flush !== 1'b1 || pc_stall !== 1'b0 || if_id_stall !== 1'b0) begin failures++; $display("FAIL pri_flush got=%0b%0b%0b exp=100", if_id_flush, pc_stall, if_id_stall); end
      tick();
      clear_inputs();
      #1;
      checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd4) begin failures++; $display("FAIL pri_counters got=%0d/%0d exp=1/4", flush_cnt, stall_cnt); end
      checks++; if (drop_pending !== 1'b0) begin failures++; $display("FAIL pri_no_drop got=%0b exp=0", drop_pending); end
   endtask

   task automatic test_redirect_inflight;
      do_reset();
      id_redirect = 1'b1; id_redirect_pc = 64'h1000; if_req_busy = 1'b1;
      #1;
      checks++; if (pc_redirect !== 1'b1 || drop_pending !== 1'b0) begin failures++; $display("FAIL inf_accept got=%0b/%0b exp=1/0", pc_redirect, drop_pending); end
      tick();
      id_redirect_pc = 64'h2000; id_load_stall = 1'b1;
      #1;
      checks++; if (drop_pending !== 1'b1) begin failures++; $display("FAIL inf_drop_entry got=%0b exp=1", drop_pending); end
      checks++; if (pc_redirect !== 1'b0 || pc_redirect_target !== 64'h0 || if_id_flush !== 1'b0) begin failures++; $display("FAIL inf_second_redir got=%0b/%0h/%0b exp=0/0/0", pc_redirect, pc_redirect_target, if_id_flush); end
      checks++; if (pc_stall !== 1'b0 || id_ex_bubble !== 1'b0) begin failures++; $display("FAIL inf_loaduse_ignored got=%0b/%0b exp=0/0", pc_stall, id_ex_bubble); end
      checks++; if (if_drop_resp !== 1'b0) begin failures++; $display("FAIL inf_no_resp got=%0b exp=0", if_drop_resp); end
      tick();
      id_redirect = 1'b0; id_load_stall = 1'b0; if_resp_valid = 1'b1; ex_busy = 1'b1;
      #1;
      checks++; if (if_drop_resp !== 1'b1 || drop_pending !== 1'b1) begin failures++; $display("FAIL inf_drop_resp got=%0b/%0b exp=1/1", if_drop_resp, drop_pending); end
      checks++; if (ex_mem_bubble !== 1'b1 || pc_stall !== 1'b1) begin failures++; $display("FAIL inf_ex_in_drop got=%0b/%0b exp=1/1", ex_mem_bubble, pc_stall); end
      tick();
      clear_inputs();
      #1;
      checks++; if (drop_pending !== 1'b0 || flush_cnt !== 4'd1) begin failures++; $display("FAIL inf_exit got=%0b/%0d exp=0/1", drop_pending, flush_cnt); end
   endtask

   task automatic test_redirect_with_resp;
      do_reset();
      id_redirect = 1'b1; id_redirect_pc = 64'h40; if_req_busy = 1'b1; if_resp_valid = 1'b1;
      #1;
      checks++; if (if_id_flush !== 1'b1 || pc_redirect !== 1'b1 || if_drop_resp !== 1'b0) begin failures++; $display("FAIL coin_flush got=%0b%0b%0b exp=110", if_id_flush, pc_redirect, if_drop_resp); end
      tick();
      clear_inputs();
      if_resp_valid = 1'b1;
      #1;
      checks++; if (drop_pending !== 1'b0 || if_drop_resp !== 1'b0) begin failures++; $display("FAIL coin_run got=%0b/%0b exp=0/0", drop_pending, if_drop_resp); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_drop;
      do_reset();
      ex_busy = 1'b1;
      tick();
      ex_busy = 1'b0; id_redirect = 1'b1; id_redirect_pc = 64'h3000; if_req_busy = 1'b1;
      tick();
      clear_inputs();
      if_req_busy = 1'b1;
      #1;
      checks++; if (drop_pending !== 1'b1 || flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin failures++; $display("FAIL rmd_setup got=%0b/%0d/%0d exp=1/1/1", drop_pending, flush_cnt, stall_cnt); end
      reset = 1'b1; if_resp_valid = 1'b1; mem_busy = 1'b1;
      #1;
      checks++; if (drop_pending !== 1'b0 || if_drop_resp !== 1'b0 || pc_stall !== 1'b0 || ex_mem_stall !== 1'b0) begin failures++; $display("FAIL rmd_outputs got=%0b%0b%0b%0b exp=0000", drop_pending, if_drop_resp, pc_stall, ex_mem_stall); end
      checks++; if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0) begin failures++; $display("FAIL rmd_cnt_gated got=%0d/%0d exp=0/0", flush_cnt, stall_cnt); end
      tick();
      reset = 1'b0;
      clear_inputs();
      if_resp_valid = 1'b1;
      #1;
      checks++; if (drop_pending !== 1'b0 || if_drop_resp !== 1'b0) begin failures++; $display("FAIL rmd_after got=%0b/%0b exp=0/0", drop_pending, if_drop_resp); end
      checks++; if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0) begin failures++; $display("FAIL rmd_cnt_cleared got=%0d/%0d exp=0/0", flush_cnt, stall_cnt); end
      clear_inputs();
   endtask

   task automatic test_counter_wrap;
      do_reset();
      ex_busy = 1'b1;
      repeat (17) tick();
      ex_busy = 1'b0;
      #1;
      checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL wrap_stall_cnt got=%0d exp=1", stall_cnt); end
      for (int i = 0; i < 17; i++) begin
         id_redirect = 1'b1; id_redirect_pc = 64'(i);
         tick();
      end
      id_redirect = 1'b0;
      #1;
      checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL wrap_flush_cnt got=%0d exp=1", flush_cnt); end
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      test_reset();
      test_load_use();
      test_priority();
      test_redirect_inflight();
      test_redirect_with_resp();
      test_reset_mid_drop();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
